char_buffer_controller: RTL and testbench



---
 rtl/char_buffer_pkg.sv | 21 ++
 rtl/char_addr_translate.sv | 38 +++
 rtl/char_buffer_controller.sv | 162 ++++++++++++++++
 tb/tb_char_buffer_controller.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/char_buffer_pkg.sv
// char_buffer_pkg: shared definitions for the character buffer controller.
//   - command opcodes accepted on cmd_op
//   - fill character used by scroll/clear operations
//   - controller state encoding
package char_buffer_pkg;

  localparam logic [2:0] OP_NOP          = 3'd0;
  localparam logic [2:0] OP_WRITE        = 3'd1;
  localparam logic [2:0] OP_SCROLL       = 3'd2;
  localparam logic [2:0] OP_CLEAR_SCREEN = 3'd3;
  localparam logic [2:0] OP_CLEAR_EOL    = 3'd4;
  localparam logic [2:0] OP_CLEAR_EOS    = 3'd5;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

endpackage

// File: rtl/char_addr_translate.sv
// char_addr_translate: combinational (x,y) -> ring-buffer address.
//   first_char : buffer address of the top-left displayed cell
//   x, y       : column / row on screen
//   address    : (first_char + y*COLS + x) wrapped into 0..ROWS*COLS-1
//   lin        : linear screen offset y*COLS + x (valid when in_range)
//   in_range   : x < COLS and y < ROWS
module char_addr_translate #(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic [ADDR_BITS-1:0] first_char,
  input  logic [COL_BITS-1:0]  x,
  input  logic [ROW_BITS-1:0]  y,
  output logic [ADDR_BITS-1:0] address,
  output logic [ADDR_BITS-1:0] lin,
  output logic                 in_range
);

  localparam int W = ADDR_BITS + 1;
  localparam logic [W-1:0] N_W = W'(ROWS * COLS);

  logic [W-1:0] lin_w;
  logic [W-1:0] sum;

  always_comb begin
    in_range = (x < COL_BITS'(COLS)) && (y < ROW_BITS'(ROWS));
    lin_w    = W'(y) * W'(COLS) + W'(x);
    // first_char < N and lin < N for in-range input, so one subtract wraps.
    sum      = {1'b0, first_char} + lin_w;
    if (sum >= N_W) sum = sum - N_W;
    address  = sum[ADDR_BITS-1:0];
    lin      = lin_w[ADDR_BITS-1:0];
  end

endmodule

// File: rtl/char_buffer_controller.sv
// char_buffer_controller: owns the char buffer write port and the scroll
// origin (first_char) for the 80x24 text display.
//   clk, reset          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_op/x/y/char     : command fields, sampled at acceptance
//   first_char          : buffer address of the top-left displayed char
//   wr_en/address/data  : registered char buffer write port
//   busy                : multi-cycle fill in progress
module char_buffer_controller
  import char_buffer_pkg::*;
#(
  parameter int ROWS      = 24,
  parameter int COLS      = 80,
  parameter int ROW_BITS  = 5,
  parameter int COL_BITS  = 7,
  parameter int ADDR_BITS = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [COL_BITS-1:0]  cmd_x,
  input  logic [ROW_BITS-1:0]  cmd_y,
  input  logic [7:0]           cmd_char,
  output logic [ADDR_BITS-1:0] first_char,
  output logic                 wr_en,
  output logic [ADDR_BITS-1:0] wr_address,
  output logic [7:0]           wr_data,
  output logic                 busy
);

  localparam int W = ADDR_BITS + 1;
  localparam logic [W-1:0] N_W    = W'(ROWS * COLS);
  localparam logic [W-1:0] COLS_W = W'(COLS);

  state_t               state;
  logic [ADDR_BITS-1:0] fill_ptr;
  logic [W-1:0]         remaining;
  logic [ADDR_BITS-1:0] pending_first;
  logic                 first_update;

  logic [ADDR_BITS-1:0] xlat_addr;
  logic [ADDR_BITS-1:0] xlat_lin;
  logic                 xlat_in_range;
  logic [W-1:0]         fc_plus_cols;
  logic [ADDR_BITS-1:0] scroll_first;
  logic [W-1:0]         fill_len;

  char_addr_translate #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .ROW_BITS  (ROW_BITS),
    .COL_BITS  (COL_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_xlat (
    .first_char (first_char),
    .x          (cmd_x),
    .y          (cmd_y),
    .address    (xlat_addr),
    .lin        (xlat_lin),
    .in_range   (xlat_in_range)
  );

  function automatic logic [ADDR_BITS-1:0] wrap_inc(input logic [ADDR_BITS-1:0] a);
    return (a == ADDR_BITS'(ROWS * COLS - 1)) ? '0 : a + 1'b1;
  endfunction

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == FILL);

  // N is a multiple of COLS, so the scrolled origin lands exactly on N.
  assign fc_plus_cols = {1'b0, first_char} + COLS_W;
  assign scroll_first = (fc_plus_cols >= N_W) ? '0 : fc_plus_cols[ADDR_BITS-1:0];

  always_comb begin
    fill_len = '0;
    case (cmd_op)
      OP_CLEAR_EOL: fill_len = COLS_W - W'(cmd_x);
      OP_CLEAR_EOS: fill_len = N_W - {1'b0, xlat_lin};
      default:      fill_len = '0;
    endcase
  end

  // The acceptance edge already issues the first write of a fill, so
  // 'remaining' counts the writes still owed after the one being issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      first_char    <= '0;
      wr_en         <= 1'b0;
      wr_address    <= '0;
      wr_data       <= '0;
      fill_ptr      <= '0;
      remaining     <= '0;
      pending_first <= '0;
      first_update  <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_WRITE: begin
                if (xlat_in_range) begin
                  wr_en      <= 1'b1;
                  wr_address <= xlat_addr;
                  wr_data    <= cmd_char;
                end
              end
              OP_SCROLL: begin
                wr_en         <= 1'b1;
                wr_address    <= first_char;
                wr_data       <= BLANK_CHAR;
                fill_ptr      <= wrap_inc(first_char);
                remaining     <= COLS_W - 1'b1;
                pending_first <= scroll_first;
                first_update  <= 1'b1;
                state         <= FILL;
              end
              OP_CLEAR_SCREEN: begin
                first_char   <= '0;
                wr_en        <= 1'b1;
                wr_address   <= '0;
                wr_data      <= BLANK_CHAR;
                fill_ptr     <= ADDR_BITS'(1);
                remaining    <= N_W - 1'b1;
                first_update <= 1'b0;
                state        <= FILL;
              end
              OP_CLEAR_EOL, OP_CLEAR_EOS: begin
                if (xlat_in_range) begin
                  wr_en        <= 1'b1;
                  wr_address   <= xlat_addr;
                  wr_data      <= BLANK_CHAR;
                  fill_ptr     <= wrap_inc(xlat_addr);
                  remaining    <= fill_len - 1'b1;
                  first_update <= 1'b0;
                  if (fill_len != W'(1)) state <= FILL;
                end
              end
              default: ;
            endcase
          end
        end
        FILL: begin
          wr_en      <= 1'b1;
          wr_address <= fill_ptr;
          wr_data    <= BLANK_CHAR;
          fill_ptr   <= wrap_inc(fill_ptr);
          remaining  <= remaining - 1'b1;
          if (remaining == W'(1)) begin
            state <= IDLE;
            if (first_update) first_char <= pending_first;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_char_buffer_controller.sv
// tb_char_buffer_controller: scoreboard bench for char_buffer_controller.
// Expected writes {address, data} are queued when a command is issued and
// popped by a monitor whenever wr_en is observed.
module tb_char_buffer_controller;

  localparam int N = 1920;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [6:0]  cmd_x;
  logic [4:0]  cmd_y;
  logic [7:0]  cmd_char;
  logic [10:0] first_char;
  logic        wr_en;
  logic [10:0] wr_address;
  logic [7:0]  wr_data;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int run_len  = 0;
  int model_fc = 0;
  logic [18:0] exp_q[$];

  char_buffer_controller #(
    .ROWS      (24),
    .COLS      (80),
    .ROW_BITS  (5),
    .COL_BITS  (7),
    .ADDR_BITS (11)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_char   (cmd_char),
    .first_char (first_char),
    .wr_en      (wr_en),
    .wr_address (wr_address),
    .wr_data    (wr_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int xlat(input int fc, input int x, input int y);
    return (fc + y * 80 + x) % N;
  endfunction

  task automatic push_write(input int addr, input logic [7:0] data);
    logic [10:0] a;
    a = 11'(addr);
    exp_q.push_back({a, data});
  endtask

  task automatic push_fill(input int start, input int k);
    for (int i = 0; i < k; i++) push_write((start + i) % N, 8'h20);
  endtask

  task automatic send_cmd(input logic [2:0] op, input int x, input int y, input logic [7:0] ch);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_value("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_x     = 7'(x);
    cmd_y     = 5'(y);
    cmd_char  = ch;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int low);
    low = 0;
    @(negedge clk);
    while (!cmd_ready && low < 5000) begin
      low++;
      @(negedge clk);
    end
    check_value("idle_reached", cmd_ready, 1);
  endtask

  task automatic do_scroll(output int low);
    send_cmd(3'd2, 0, 0, 8'h00);
    push_fill(model_fc, 80);
    wait_idle(low);
    model_fc = (model_fc + 80) % N;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [18:0] e;
    if (wr_en) begin
      run_len++;
      wr_count++;
      check_value("wr_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_value("wr_address", wr_address, e[18:8]);
        check_value("wr_data", wr_data, e[7:0]);
      end
    end else begin
      run_len = 0;
    end
  end

  initial begin
    int low;
    int base;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_char  = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_value("rst_first_char", first_char, 0);
      check_value("rst_wr_en", wr_en, 0);
      check_value("rst_cmd_ready", cmd_ready, 1);
      check_value("rst_busy", busy, 0);
    end

    // Single write, then a three-command burst
    push_write(xlat(0, 5, 2), 8'h41);
    send_cmd(3'd1, 5, 2, 8'h41);
    repeat (3) @(negedge clk);
    push_write(xlat(0, 0, 0), 8'h42);
    send_cmd(3'd1, 0, 0, 8'h42);
    push_write(xlat(0, 79, 23), 8'h43);
    send_cmd(3'd1, 79, 23, 8'h43);
    push_write(xlat(0, 10, 1), 8'h44);
    send_cmd(3'd1, 10, 1, 8'h44);
    @(negedge clk);
    #1;
    check_value("burst_run_len", run_len, 3);

    // First scroll and wrapped write
    do_scroll(low);
    check_value("scroll_low_cycles", low, 79);
    check_value("scroll_first_char", first_char, 80);
    check_value("scroll_busy_done", busy, 0);
    push_write(xlat(model_fc, 0, 23), 8'h5a);
    send_cmd(3'd1, 0, 23, 8'h5a);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 22; i++) do_scroll(low);
    check_value("fc_after_23", first_char, 1840);

    // Clear to end of line across the ring wrap
    send_cmd(3'd4, 75, 3, 8'h00);
    push_fill(xlat(model_fc, 75, 3), 5);
    wait_idle(low);
    check_value("eol_low_cycles", low, 4);

    do_scroll(low);
    check_value("fc_after_24", first_char, 0);

    // Single-cell EOL and short EOS at screen end
    send_cmd(3'd4, 79, 0, 8'h00);
    push_fill(xlat(model_fc, 79, 0), 1);
    wait_idle(low);
    check_value("eol1_low_cycles", low, 0);
    send_cmd(3'd5, 70, 23, 8'h00);
    push_fill(xlat(model_fc, 70, 23), 10);
    wait_idle(low);
    check_value("eos_low_cycles", low, 9);
    repeat (2) @(negedge clk);

    // Dropped and no-op commands
    base = wr_count;
    send_cmd(3'd1, 80, 0, 8'h55);
    send_cmd(3'd5, 0, 24, 8'h00);
    send_cmd(3'd4, 100, 0, 8'h00);
    send_cmd(3'd0, 1, 1, 8'h00);
    send_cmd(3'd7, 1, 1, 8'h00);
    repeat (3) @(negedge clk);
    check_value("drop_ready", cmd_ready, 1);
    check_value("drop_first_char", first_char, 0);
    check_value("drop_no_writes", wr_count - base, 0);

    // Clear screen from a scrolled origin, aborted by reset
    for (int i = 0; i < 5; i++) do_scroll(low);
    check_value("fc_400", first_char, 400);
    repeat (2) @(negedge clk);
    base = wr_count;
    send_cmd(3'd3, 0, 0, 8'h00);
    push_fill(0, 100);
    @(negedge clk);
    check_value("cls_first_char", first_char, 0);
    check_value("cls_busy", busy, 1);
    repeat (99) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_value("abort_wr_en", wr_en, 0);
    check_value("abort_ready", cmd_ready, 1);
    check_value("abort_busy", busy, 0);
    check_value("abort_first_char", first_char, 0);
    repeat (5) @(negedge clk);
    check_value("abort_write_count", wr_count - base, 100);
    check_value("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
